tx_seq_ctrl: RTL and testbench

TX_SEQ_CTRL -- requirements
Module: tx_seq_ctrl

---
 rtl/tx_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tx_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_seq_ctrl.sv
// tx_seq_ctrl: transmit-side sequencer that feeds an MSK coder with a zero
// preamble, an 8-bit start-of-frame delimiter (LSB first) and then payload
// bits fetched one at a time from a FIFO. A frame ends normally after
// inFrameLen payload bits, or early on FIFO underrun, inAbort or reset.
module tx_seq_ctrl #(
    parameter int         PREAMBLE_BITS  = 32,
    parameter logic [7:0] SFD_PATTERN    = 8'hA7,
    parameter int         UNDERRUN_LIMIT = 16
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [7:0] inFrameLen,
    input  logic       inAbort,
    input  logic       inFifoEmpty,
    input  logic       inFifoData,
    input  logic       inCoderReady,
    output logic       outReadEnable,
    output logic       outCoderData,
    output logic       outCoderEmpty,
    output logic       outBusy,
    output logic       outDone,
    output logic       outUnderrun,
    output logic [7:0] outBitCount
);

    // The bit counter serves both the preamble and the 8-bit delimiter,
    // so it is wide enough for whichever of the two is longer.
    localparam int BitCntMax = (PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8;
    localparam int BitCntW   = $clog2(BitCntMax);
    localparam int UrunW     = (UNDERRUN_LIMIT > 2) ? $clog2(UNDERRUN_LIMIT) : 1;

    localparam logic [BitCntW-1:0] PREAMBLE_LAST = BitCntW'(PREAMBLE_BITS - 1);
    localparam logic [BitCntW-1:0] SFD_LAST      = BitCntW'(7);
    localparam logic [UrunW-1:0]   URUN_LAST     = UrunW'(UNDERRUN_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        FETCH,
        WAIT_DATA,
        SEND,
        DONE
    } stateT;

    stateT               stateReg,     stateNext;
    logic [BitCntW-1:0]  bitCntReg,    bitCntNext;
    logic [UrunW-1:0]    urunCntReg,   urunCntNext;
    logic [7:0]          bitCountReg,  bitCountNext;
    logic [7:0]          frameLenReg,  frameLenNext;
    logic                dataBitReg,   dataBitNext;
    logic                underrunReg,  underrunNext;

    // State and datapath registers; reset overrides every other input.
    always_ff @(posedge inClock) begin
        if (inReset) begin
            stateReg    <= IDLE;
            bitCntReg   <= '0;
            urunCntReg  <= '0;
            bitCountReg <= '0;
            frameLenReg <= '0;
            dataBitReg  <= 1'b0;
            underrunReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            bitCntReg   <= bitCntNext;
            urunCntReg  <= urunCntNext;
            bitCountReg <= bitCountNext;
            frameLenReg <= frameLenNext;
            dataBitReg  <= dataBitNext;
            underrunReg <= underrunNext;
        end
    end

    // Next-state and counter updates; abort is applied last so it wins.
    always_comb begin
        stateNext    = stateReg;
        bitCntNext   = bitCntReg;
        urunCntNext  = urunCntReg;
        bitCountNext = bitCountReg;
        frameLenNext = frameLenReg;
        dataBitNext  = dataBitReg;
        underrunNext = 1'b0;

        case (stateReg)
            IDLE: begin
                // A zero-length request would never produce a payload bit.
                if (inStart && (inFrameLen != 8'd0)) begin
                    frameLenNext = inFrameLen;
                    bitCountNext = 8'd0;
                    bitCntNext   = '0;
                    urunCntNext  = '0;
                    stateNext    = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (inCoderReady) begin
                    if (bitCntReg == PREAMBLE_LAST) begin
                        bitCntNext = '0;
                        stateNext  = SFD;
                    end else begin
                        bitCntNext = bitCntReg + BitCntW'(1);
                    end
                end
            end
            SFD: begin
                if (inCoderReady) begin
                    if (bitCntReg == SFD_LAST) begin
                        bitCntNext = '0;
                        stateNext  = FETCH;
                    end else begin
                        bitCntNext = bitCntReg + BitCntW'(1);
                    end
                end
            end
            FETCH: begin
                if (!inFifoEmpty) begin
                    urunCntNext = '0;
                    stateNext   = WAIT_DATA;
                end else if (urunCntReg == URUN_LAST) begin
                    urunCntNext  = '0;
                    underrunNext = 1'b1;
                    stateNext    = IDLE;
                end else begin
                    urunCntNext = urunCntReg + UrunW'(1);
                end
            end
            WAIT_DATA: begin
                // FIFO read data is valid the cycle after the strobe.
                dataBitNext = inFifoData;
                stateNext   = SEND;
            end
            SEND: begin
                if (inCoderReady) begin
                    bitCountNext = bitCountReg + 8'd1;
                    if ((bitCountReg + 8'd1) == frameLenReg) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = FETCH;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Abort discards anything else this cycle would have done.
        if ((stateReg != IDLE) && inAbort) begin
            stateNext    = IDLE;
            bitCntNext   = bitCntReg;
            urunCntNext  = urunCntReg;
            bitCountNext = bitCountReg;
            frameLenNext = frameLenReg;
            dataBitNext  = dataBitReg;
            underrunNext = 1'b0;
        end
    end

    // Output decode: everything but the read strobe depends on state only.
    always_comb begin
        outReadEnable = 1'b0;
        outCoderData  = 1'b0;
        outCoderEmpty = 1'b1;
        case (stateReg)
            PREAMBLE: begin
                outCoderEmpty = 1'b0;
            end
            SFD: begin
                outCoderData  = SFD_PATTERN[bitCntReg[2:0]];
                outCoderEmpty = 1'b0;
            end
            FETCH: begin
                outReadEnable = ~inFifoEmpty;
            end
            SEND: begin
                outCoderData  = dataBitReg;
                outCoderEmpty = 1'b0;
            end
            default: begin
                outCoderEmpty = 1'b1;
            end
        endcase
        outBusy     = (stateReg != IDLE);
        outDone     = (stateReg == DONE);
        outUnderrun = underrunReg;
        outBitCount = bitCountReg;
    end

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// tb_tx_seq_ctrl: scoreboard bench for tx_seq_ctrl. Expected coder bits are
// queued when a frame is set up and popped whenever the coder accepts a bit.
// A behavioural FIFO supplies payload bits one cycle after each read strobe.
module tb_tx_seq_ctrl;

    logic       inClock = 1'b0;
    logic       inReset;
    logic       inStart;
    logic [7:0] inFrameLen;
    logic       inAbort;
    logic       inFifoEmpty = 1'b1;
    logic       inFifoData = 1'b0;
    logic       inCoderReady = 1'b0;
    logic       outReadEnable;
    logic       outCoderData;
    logic       outCoderEmpty;
    logic       outBusy;
    logic       outDone;
    logic       outUnderrun;
    logic [7:0] outBitCount;

    tx_seq_ctrl dut (
        .inClock      (inClock),
        .inReset      (inReset),
        .inStart      (inStart),
        .inFrameLen   (inFrameLen),
        .inAbort      (inAbort),
        .inFifoEmpty  (inFifoEmpty),
        .inFifoData   (inFifoData),
        .inCoderReady (inCoderReady),
        .outReadEnable(outReadEnable),
        .outCoderData (outCoderData),
        .outCoderEmpty(outCoderEmpty),
        .outBusy      (outBusy),
        .outDone      (outDone),
        .outUnderrun  (outUnderrun),
        .outBitCount  (outBitCount)
    );

    always #5 inClock = ~inClock;

    int compared   = 0;
    int mismatched = 0;
    bit expQ[$];
    bit fifoQ[$];
    bit readReq     = 1'b0;
    int readyMode   = 0;   // 0 off, 1 every 4th cycle, 2 always, 3 manual
    bit manualReady = 1'b0;
    int cyc         = 0;
    int readCnt     = 0;
    int doneCnt     = 0;
    int urunCnt     = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge inClock);
        if (!inReset) begin
            if (inCoderReady && !outCoderEmpty && !inAbort) begin
                if (expQ.size() == 0) checkVal("bit_queue_depth", expQ.size(), 1);
                else checkVal("coder_bit", int'(outCoderData), int'(expQ.pop_front()));
            end
            if (outReadEnable) readCnt++;
            if (outDone) doneCnt++;
            if (outUnderrun) urunCnt++;
        end
        readReq = outReadEnable && !inReset;
        @(posedge inClock);
        #1;
    endtask

    // FIFO model: data appears the cycle after the strobe.
    always @(posedge inClock) begin
        #2;
        if (readReq && fifoQ.size() > 0) inFifoData = fifoQ.pop_front();
        inFifoEmpty = (fifoQ.size() == 0);
    end

    // Coder ready pattern generator.
    always @(posedge inClock) begin
        #3;
        cyc++;
        case (readyMode)
            0:       inCoderReady = 1'b0;
            1:       inCoderReady = (cyc % 4 == 0);
            2:       inCoderReady = 1'b1;
            default: inCoderReady = manualReady;
        endcase
    end

    task automatic pushHeader();
        logic [7:0] sfd;
        sfd = 8'hA7;
        for (int i = 0; i < 32; i++) expQ.push_back(1'b0);
        for (int i = 0; i < 8; i++) expQ.push_back(sfd[i]);
    endtask

    task automatic loadBit(input bit b);
        fifoQ.push_back(b);
        expQ.push_back(b);
    endtask

    task automatic startFrame(input int len);
        inFrameLen = 8'(len);
        inStart    = 1'b1;
        cycle();
        inStart    = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        while (outBusy && n < budget) begin
            cycle();
            n++;
        end
        checkVal({tag, "_timeout"}, int'(n < budget), 1);
        cycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_rd"},    int'(outReadEnable), 0);
        checkVal({tag, "_data"},  int'(outCoderData),  0);
        checkVal({tag, "_empty"}, int'(outCoderEmpty), 1);
        checkVal({tag, "_busy"},  int'(outBusy),       0);
        checkVal({tag, "_done"},  int'(outDone),       0);
        checkVal({tag, "_urun"},  int'(outUnderrun),   0);
        checkVal({tag, "_cnt"},   int'(outBitCount),   0);
    endtask

    initial begin
        int r0, d0, u0, n;
        inReset = 1'b1; inStart = 1'b0; inFrameLen = 8'd0; inAbort = 1'b0;
        repeat (3) cycle();
        checkResetOutputs("reset");
        inReset = 1'b0;
        cycle();

        // Nominal frame
        readyMode = 1;
        pushHeader();
        loadBit(1); loadBit(0); loadBit(1); loadBit(1);
        r0 = readCnt; d0 = doneCnt; u0 = urunCnt;
        cycle();
        startFrame(4);
        waitIdle("nominal", 2000);
        checkVal("nominal_reads", readCnt - r0, 4);
        checkVal("nominal_done", doneCnt - d0, 1);
        checkVal("nominal_urun", urunCnt - u0, 0);
        checkVal("nominal_cnt", int'(outBitCount), 4);
        checkVal("nominal_left", expQ.size(), 0);
        $display("frame nominal: len=4 reads=%0d done=%0d bitCount=%0d", readCnt - r0, doneCnt - d0, outBitCount);

        // Underrun
        pushHeader();
        loadBit(1); loadBit(0);
        r0 = readCnt; d0 = doneCnt; u0 = urunCnt;
        cycle();
        startFrame(3);
        n = 0;
        while (outBitCount != 8'd2 && n < 2000) begin cycle(); n++; end
        checkVal("urun_reach2_timeout", int'(n < 2000), 1);
        n = 0;
        while (!outUnderrun && n < 100) begin cycle(); n++; end
        checkVal("urun_empty_cycles", n, 16);
        checkVal("urun_busy", int'(outBusy), 0);
        cycle();
        checkVal("urun_pulses", urunCnt - u0, 1);
        checkVal("urun_pulse_width", int'(outUnderrun), 0);
        checkVal("urun_done", doneCnt - d0, 0);
        checkVal("urun_cnt", int'(outBitCount), 2);
        checkVal("urun_reads", readCnt - r0, 2);
        checkVal("urun_left", expQ.size(), 0);
        $display("frame underrun: len=3 reads=%0d underruns=%0d bitCount=%0d", readCnt - r0, urunCnt - u0, outBitCount);

        // Abort during SFD (counter 3) together with coder ready
        readyMode = 3; manualReady = 1'b1;
        for (int i = 0; i < 32; i++) expQ.push_back(1'b0);
        expQ.push_back(1); expQ.push_back(1); expQ.push_back(1);
        for (int i = 0; i < 4; i++) fifoQ.push_back(1'b1);
        r0 = readCnt; d0 = doneCnt;
        repeat (2) cycle();
        startFrame(4);
        repeat (35) cycle();
        inAbort = 1'b1;
        cycle();
        inAbort = 1'b0;
        checkVal("abort_busy", int'(outBusy), 0);
        checkVal("abort_empty", int'(outCoderEmpty), 1);
        repeat (5) cycle();
        checkVal("abort_reads", readCnt - r0, 0);
        checkVal("abort_done", doneCnt - d0, 0);
        checkVal("abort_left", expQ.size(), 0);
        $display("frame abort: reads=%0d done=%0d busy=%0d", readCnt - r0, doneCnt - d0, outBusy);
        manualReady = 1'b0; readyMode = 1;
        fifoQ.delete();
        repeat (2) cycle();

        // Reset in the middle of SEND, then a complete new frame
        pushHeader();
        loadBit(1); loadBit(0); loadBit(1); loadBit(1);
        cycle();
        startFrame(4);
        n = 0;
        while (!(outBitCount == 8'd1 && !outCoderEmpty) && n < 2000) begin cycle(); n++; end
        checkVal("rst_reach_send_timeout", int'(n < 2000), 1);
        inReset = 1'b1;
        cycle();
        inReset = 1'b0;
        checkResetOutputs("midrst");
        expQ.delete(); fifoQ.delete();
        cycle();
        pushHeader();
        loadBit(0); loadBit(1); loadBit(1); loadBit(0);
        r0 = readCnt; d0 = doneCnt;
        cycle();
        startFrame(4);
        waitIdle("after_rst", 2000);
        checkVal("after_rst_reads", readCnt - r0, 4);
        checkVal("after_rst_done", doneCnt - d0, 1);
        checkVal("after_rst_cnt", int'(outBitCount), 4);
        checkVal("after_rst_left", expQ.size(), 0);
        $display("frame after reset: len=4 reads=%0d done=%0d bitCount=%0d", readCnt - r0, doneCnt - d0, outBitCount);

        // Ignore cases: zero length, then start during preamble
        inFrameLen = 8'd0; inStart = 1'b1;
        cycle();
        inStart = 1'b0;
        checkVal("zero_len_busy", int'(outBusy), 0);
        cycle();
        checkVal("zero_len_busy2", int'(outBusy), 0);
        checkVal("zero_len_cnt_held", int'(outBitCount), 4);
        pushHeader();
        loadBit(0); loadBit(1);
        r0 = readCnt; d0 = doneCnt;
        cycle();
        startFrame(2);
        repeat (5) cycle();
        inFrameLen = 8'd5; inStart = 1'b1;
        cycle();
        inStart = 1'b0;
        waitIdle("restart", 2000);
        checkVal("restart_done", doneCnt - d0, 1);
        checkVal("restart_cnt", int'(outBitCount), 2);
        checkVal("restart_reads", readCnt - r0, 2);
        checkVal("restart_left", expQ.size(), 0);
        $display("frame ignore-start: len=2 reads=%0d done=%0d bitCount=%0d", readCnt - r0, doneCnt - d0, outBitCount);

        // Maximum length with ready held high
        readyMode = 2;
        pushHeader();
        for (int i = 0; i < 255; i++) loadBit(1'($urandom_range(0, 1)));
        r0 = readCnt; d0 = doneCnt; u0 = urunCnt;
        cycle();
        startFrame(255);
        waitIdle("max", 5000);
        checkVal("max_reads", readCnt - r0, 255);
        checkVal("max_done", doneCnt - d0, 1);
        checkVal("max_urun", urunCnt - u0, 0);
        checkVal("max_cnt", int'(outBitCount), 255);
        checkVal("max_left", expQ.size(), 0);
        repeat (3) cycle();
        checkVal("max_cnt_held", int'(outBitCount), 255);
        $display("frame max: len=255 reads=%0d done=%0d bitCount=%0d", readCnt - r0, doneCnt - d0, outBitCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
